fetch_unit: RTL and testbench

//  Instruction-fetch stage and IF/ID pipeline register for the DLX core. Holds the PC and

---
 rtl/fetch_unit_if.sv | 39 +++
 rtl/fetch_unit.sv | 106 ++++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
//------------------------------------------------------------------------------
// Module  : fetch_unit_if
// Brief   : Instruction-memory and IF/ID-side signal bundle for fetch_unit.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if;
  logic        imem_req;
  logic [0:31] imem_addr;
  logic        imem_ready;
  logic [0:31] imem_rdata;
  logic        stall_id;
  logic        branch;
  logic        branch_ne;
  logic        jump;
  logic        rs_zero;
  logic [0:15] imm16;
  logic [0:25] imm26;
  logic [0:31] instr_id;
  logic [0:31] pc_id;
  logic [0:31] pc_plus4_id;
  logic        valid_id;
  logic        redirect;

  modport master (
    output imem_req, imem_addr, instr_id, pc_id, pc_plus4_id, valid_id, redirect,
    input  imem_ready, imem_rdata, stall_id, branch, branch_ne, jump, rs_zero,
           imm16, imm26
  );

  modport slave (
    input  imem_req, imem_addr, instr_id, pc_id, pc_plus4_id, valid_id, redirect,
    output imem_ready, imem_rdata, stall_id, branch, branch_ne, jump, rs_zero,
           imm16, imm26
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
//------------------------------------------------------------------------------
// Module  : fetch_unit
// Brief   : DLX instruction fetch with PC, IF/ID register and ID-stage redirect.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter logic [0:31] RESET_PC  = 32'h0000_0000,
  parameter logic [0:31] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  fetch_unit_if.master  bus
);

  typedef enum logic [0:0] {
    S_BOOT  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  localparam logic [0:31] c_align_mask = 32'hFFFF_FFFC;

  state_t      r_state;
  state_t      w_state_next;
  logic [0:31] r_pc;
  logic [0:31] r_instr_id;
  logic [0:31] r_pc_id;
  logic [0:31] r_pc_plus4_id;
  logic        r_valid_id;

  logic        w_fetch;
  logic        w_take;
  logic        w_redirect;
  logic [0:31] w_offset;
  logic [0:31] w_target;
  logic [0:31] w_pc_plus4;

  always_comb begin
    w_state_next = r_state;
    w_fetch      = 1'b0;
    if (r_state == S_BOOT) begin
      w_state_next = S_FETCH;
    end else begin
      w_fetch = 1'b1;
    end
  end

  // Jump has priority over branch when selecting the offset.
  always_comb begin
    w_take = r_valid_id & (bus.jump | (bus.branch & bus.rs_zero) |
                           (bus.branch_ne & ~bus.rs_zero));
    w_offset = bus.jump ? {{6{bus.imm26[0]}}, bus.imm26}
                        : {{16{bus.imm16[0]}}, bus.imm16};
    w_target   = (r_pc_plus4_id + w_offset) & c_align_mask;
    w_redirect = w_fetch & w_take & ~bus.stall_id;
    w_pc_plus4 = r_pc + 32'd4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A stalled cycle drops any returned word; the same pc is simply re-requested.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_instr_id    <= NOP_INSTR;
      r_pc_id       <= 32'h0;
      r_pc_plus4_id <= 32'h0;
      r_valid_id    <= 1'b0;
    end else if (w_fetch) begin
      if (w_redirect) begin
        r_pc       <= w_target;
        r_instr_id <= NOP_INSTR;
        r_valid_id <= 1'b0;
      end else if (!bus.stall_id) begin
        if (bus.imem_ready) begin
          r_instr_id    <= bus.imem_rdata;
          r_pc_id       <= r_pc;
          r_pc_plus4_id <= w_pc_plus4;
          r_valid_id    <= 1'b1;
          r_pc          <= w_pc_plus4;
        end else begin
          r_instr_id <= NOP_INSTR;
          r_valid_id <= 1'b0;
        end
      end
    end
  end

  assign bus.imem_req    = w_fetch;
  assign bus.imem_addr   = r_pc & c_align_mask;
  assign bus.instr_id    = r_instr_id;
  assign bus.pc_id       = r_pc_id;
  assign bus.pc_plus4_id = r_pc_plus4_id;
  assign bus.valid_id    = r_valid_id;
  assign bus.redirect    = w_redirect;

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
//------------------------------------------------------------------------------
// Module  : tb_fetch_unit
// Brief   : Randomized self-checking bench for fetch_unit with a reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_unit;
  localparam logic [31:0] c_nop = 32'h0000_0013;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  bit          m_boot;
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcid;
  logic [31:0] m_pc4;
  bit          m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic model_reset();
    m_boot  = 1'b1;
    m_pc    = 32'h0;
    m_instr = c_nop;
    m_pcid  = 32'h0;
    m_pc4   = 32'h0;
    m_valid = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_req",   32'(bus.imem_req), 32'h0);
    check("rst_addr",  bus.imem_addr,     32'h0);
    check("rst_instr", bus.instr_id,      c_nop);
    check("rst_pcid",  bus.pc_id,         32'h0);
    check("rst_pc4",   bus.pc_plus4_id,   32'h0);
    check("rst_valid", 32'(bus.valid_id), 32'h0);
  endtask

  // Called at a falling edge; drives one cycle of inputs, checks, advances model.
  task automatic step(input bit rdy, input bit stall, input bit br, input bit bne,
                      input bit j, input bit rz, input logic [15:0] i16,
                      input logic [25:0] i26);
    logic [31:0] off;
    logic [31:0] tgt;
    bit          take;
    bit          redir;
    bus.imem_ready = rdy;
    bus.stall_id   = stall;
    bus.branch     = br;
    bus.branch_ne  = bne;
    bus.jump       = j;
    bus.rs_zero    = rz;
    bus.imm16      = i16;
    bus.imm26      = i26;
    bus.imem_rdata = rdy ? mem_word(bus.imem_addr) : $urandom;
    #1;
    take  = m_valid && (j || (br && rz) || (bne && !rz));
    redir = !m_boot && take && !stall;
    check("imem_req",    32'(bus.imem_req), 32'(!m_boot));
    check("imem_addr",   bus.imem_addr,     m_pc);
    check("instr_id",    bus.instr_id,      m_instr);
    check("pc_id",       bus.pc_id,         m_pcid);
    check("pc_plus4_id", bus.pc_plus4_id,   m_pc4);
    check("valid_id",    32'(bus.valid_id), 32'(m_valid));
    check("redirect",    32'(bus.redirect), 32'(redir));
    off = j ? {{6{i26[25]}}, i26} : {{16{i16[15]}}, i16};
    tgt = (m_pc4 + off) & 32'hFFFF_FFFC;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (redir) begin
      m_pc    = tgt;
      m_instr = c_nop;
      m_valid = 1'b0;
    end else if (!stall) begin
      if (rdy) begin
        m_instr = mem_word(m_pc);
        m_pcid  = m_pc;
        m_pc4   = m_pc + 32'd4;
        m_valid = 1'b1;
        m_pc    = m_pc + 32'd4;
      end else begin
        m_instr = c_nop;
        m_valid = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy, input bit stall);
    step(rdy, stall, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
  endtask

  task automatic rnd_step();
    step($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
         $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
         $urandom_range(0, 15) == 0, 1'($urandom),
         16'($urandom_range(0, 63)) - 16'd32,
         26'($urandom_range(0, 255)) - 26'd128);
  endtask

  initial begin
    bus.imem_ready = 1'b0;
    bus.imem_rdata = 32'h0;
    bus.stall_id   = 1'b0;
    bus.branch     = 1'b0;
    bus.branch_ne  = 1'b0;
    bus.jump       = 1'b0;
    bus.rs_zero    = 1'b0;
    bus.imm16      = 16'h0;
    bus.imm26      = 26'h0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_values();
    reset_n = 1'b1;

    // Zero-wait fetch of the first words, then a 3-cycle memory wait.
    repeat (3) idle(1'b1, 1'b0);
    repeat (3) idle(1'b0, 1'b0);
    repeat (3) idle(1'b1, 1'b0);
    // Two-cycle stall, then release.
    repeat (2) idle(1'b1, 1'b1);
    repeat (2) idle(1'b1, 1'b0);
    // beqz taken backwards, then bnez with rs_zero=1 (not taken).
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hFFF8, 26'h0);
    repeat (2) idle(1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'hFFF8, 26'h0);
    // Jump while stalled is deferred until the stall drops.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000100);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000100);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000100);
    repeat (3) idle(1'b1, 1'b0);
    // Jump to the top word so the next fetch wraps to address 0.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 26'(32'hFFFF_FFFC - m_pc4));
    repeat (4) idle(1'b1, 1'b0);

    for (int i = 0; i < 600; i++) rnd_step();

    // Asynchronous reset in the middle of a memory wait.
    idle(1'b0, 1'b0);
    bus.imem_ready = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 200; i++) rnd_step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
